// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, types and the 4-bit priority helper for the 8-to-3 encoder.
package pe_pkg;
    localparam int PE_IN_W  = 8;
    localparam int PE_OUT_W = 3;
    typedef logic [7:0] pe_req_t;
    typedef logic [2:0] pe_idx_t;
    function automatic logic [1:0] enc4(input logic [3:0] v);
        return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/pe8_core.sv
// pe8_core: combinational 8-bit priority encoder built from two 4-bit stages.
module pe8_core
    import pe_pkg::*;
(
    input  logic [7:0] in,
    output logic [2:0] idx,
    output logic       any_set
);
    logic [3:0] hi;
    logic [3:0] lo;
    assign hi      = in[7:4];
    assign lo      = in[3:0];
    assign idx     = |hi ? {1'b1, enc4(hi)} : {1'b0, enc4(lo)};
    assign any_set = |in;
endmodule

// File: rtl/priority_encoder_8to3.sv
// priority_encoder_8to3: registered index of the highest set request bit, with valid flag.
module priority_encoder_8to3
    import pe_pkg::*;
#(
    parameter int IN_W  = PE_IN_W,
    parameter int OUT_W = PE_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             valid
);
    if (IN_W != PE_IN_W || OUT_W != PE_OUT_W) begin : g_bad_width
        $error("priority_encoder_8to3 supports only IN_W=8, OUT_W=3");
    end
    pe_idx_t idx;
    logic    any_set;
    pe8_core u_core (
        .in      (in),
        .idx     (idx),
        .any_set (any_set)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            valid <= 1'b0;
        end else if (en) begin
            out   <= idx;
            valid <= any_set;
        end
    end
endmodule

// File: tb/tb_priority_encoder_8to3.sv
// tb_priority_encoder_8to3: directed and exhaustive scoreboard checks of the registered encoder.
module tb_priority_encoder_8to3;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [7:0] in = 8'hFF;
    logic [2:0] out;
    logic       valid;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];

    priority_encoder_8to3 dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in    (in),
        .out   (out),
        .valid (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_idx(input logic [7:0] v);
        logic [2:0] r = 3'd0;
        for (int b = 0; b < 8; b++) if (v[b]) r = b[2:0];
        return r;
    endfunction

    // Drive one cycle, queue its expected result, then compare just after the edge.
    task automatic step(input logic r, input logic e, input logic [7:0] v,
                        input logic [2:0] xo, input logic xv, input string tag);
        logic [3:0] x;
        rst = r;
        en  = e;
        in  = v;
        exp_q.push_back({xo, xv});
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        n_cmp++;
        assert ({out, valid} === x) else begin
            n_fail++;
            $error("FAIL %s: got out=%0d valid=%0b, expected out=%0d valid=%0b",
                   tag, out, valid, x[3:1], x[0]);
        end
    endtask

    initial begin
        int k;
        logic [2:0] m_out;
        logic       m_val;
        @(negedge clk);
        step(1, 1, 8'hFF, 0, 0, "reset_c0");
        step(1, 1, 8'hFF, 0, 0, "reset_c1");
        step(0, 1, 8'hFF, 7, 1, "reset_release");
        step(0, 1, 8'b1000_0001, 7, 1, "sweep_81");
        step(0, 1, 8'b1110_0010, 7, 1, "sweep_e2");
        step(0, 1, 8'b0011_0100, 5, 1, "sweep_34");
        step(0, 1, 8'b0001_1000, 4, 1, "sweep_18");
        step(0, 1, 8'b0011_1100, 5, 1, "sweep_3c");
        step(0, 1, 8'b0100_0000, 6, 1, "sweep_40");
        step(0, 1, 8'b1000_0110, 7, 1, "sweep_86");
        step(0, 1, 8'b0001_1000, 4, 1, "repeat_a");
        step(0, 1, 8'b0001_1000, 4, 1, "repeat_b");
        step(0, 1, 8'h00, 0, 0, "zero");
        step(0, 1, 8'h01, 0, 1, "lsb");
        step(0, 1, 8'h03, 1, 1, "two_low");
        step(0, 1, 8'h20, 5, 1, "hold_load");
        step(0, 0, 8'h80, 5, 1, "hold_0");
        step(0, 0, 8'h80, 5, 1, "hold_1");
        step(0, 0, 8'h80, 5, 1, "hold_2");
        step(0, 1, 8'h80, 7, 1, "hold_release");
        step(1, 0, 8'h55, 0, 0, "mid_reset_en0");
        step(0, 0, 8'h55, 0, 0, "post_reset_hold");
        step(0, 1, 8'h55, 6, 1, "post_reset_load");
        k = $urandom_range(0, 255);
        for (int i = 0; i < 256; i++) begin
            if (i == k) step(1, 1, i[7:0], 0, 0, "exh_reset");
            m_out = ref_idx(i[7:0]);
            m_val = |i[7:0];
            step(0, 1, i[7:0], m_out, m_val, $sformatf("exh_%02h", i[7:0]));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
